inflight_queue_ctrl: RTL
========================

# inflight_queue_ctrl

Controller for the prefetcher's cyclic in-flight request window. It allocates entries at the tail, accepts out-of-order completion notices by entry index, and retires completed entries strictly in order from the head. It derives the live-entry mask from the head/tail pointers through a cyclic range-mask sub-block, and uses that mask to qualify completions and drive downstream masking logic.

## Interface
- LOG_DEPTH, 3: log2 of window depth
- DEPTH, 1<<LOG_DEPTH: number of entries
- ID_WIDTH, 4: width of the transaction ID stored per entry

- clk  in  1  clock, all state rising-edge
- resetN  in  1  reset, asynchronous and active-low
- allocValid  in  1  request to allocate one entry
- allocId  in  ID_WIDTH  ID stored in the allocated entry
- allocReady  out  1  entry available (not full)
- allocIdx  out  LOG_DEPTH  index that the next allocation receives (tail index)
- doneValid  in  1  completion notice
- doneIdx  in  LOG_DEPTH  entry index being completed
- errDone  out  1  one-cycle pulse: previous cycle's completion was illegal
- retireValid  out  1  head entry is complete
- retireReady  in  1  consumer accepts retire
- retireId  out  ID_WIDTH  ID of head entry
- retireIdx  out  LOG_DEPTH  head index
- validMask  out  DEPTH  live entries [head, tail), cyclic
- doneMask  out  DEPTH  live entries already completed
- count  out  LOG_DEPTH+1  live entry count, 0..DEPTH
- flush  in  1  drop all entries (present only with INFLIGHT_FLUSH_EN)

## Operation
- headPtr and tailPtr are each LOG_DEPTH+1 bits, with the MSB as the wrap bit. Empty when the pointers are equal. Full when the indices are equal and the wrap bits differ. count = tailPtr - headPtr, mod 2^(LOG_DEPTH+1).
- validMask is the cyclic range mask from head index up to, but not including, tail index. It is forced to all-0 when empty and all-1 when full. The range generator returns all-1 for equal indices, so it must be gated with empty.
- Alloc: allocReady = !full. On allocValid && allocReady, store allocId at tailIdx, clear done[tailIdx], and increment tailPtr. Full does not bypass same-cycle retire; allocReady stays 0.
- Done: legal when validMask[doneIdx] && !done[doneIdx]; a legal notice sets done[doneIdx]. A notice that is not live or is a duplicate has no state effect, and errDone pulses on the next cycle. The mask used for this check is the pre-edge mask, so a notice for the entry being allocated in the same cycle is illegal.
- Retire: retireValid = !empty && done[headIdx]. On retireValid && retireReady, clear done[headIdx] and increment headPtr.
- doneMask = done & validMask.
- Alloc, done (to a different index) and retire in the same cycle all take effect independently. A done to the head entry and a retire in the same cycle cannot conflict, because a retire requires done to already be set.

## Timing
- Reset values: pointers 0, done 0, ID storage don't-care, allocReady 1, allocIdx 0, retireValid 0, retireId don't-care, retireIdx 0, validMask 0, doneMask 0, count 0, errDone 0.
- All outputs except errDone are combinational from registered state; there is no input-to-output combinational path.
- Alloc → entry visible in validMask/count next cycle.
- Done → retireValid at the earliest on the next cycle, giving a minimum done→retire latency of 1.
- errDone is registered and asserts 1 cycle after the offending notice.
- Reset assertion mid-operation clears all state immediately, with no handshake completion.

## Configuration
- INFLIGHT_FLUSH_EN defined: the flush port exists. On flush, headPtr ← tailPtr and all done bits clear. Flush has priority over alloc, done and retire in that cycle; those are ignored, allocReady is still driven, and errDone is not raised.
- INFLIGHT_FLUSH_EN undefined: the flush port and logic are absent.

## Structure
- Shared package holds:
  - the pointer typedef (LOG_DEPTH+1 bits)
  - the index typedef
  - the entry-ID typedef
  - the full/empty helper functions
- One sub-module, range_mask: combinational cyclic mask from a head index to a tail index, exclusive. It is instantiated once for validMask.
- ID storage is a flat register array, DEPTH × ID_WIDTH, with no RAM macro.

## Test plan
- Reset, then check idle outputs: allocReady=1, validMask=0, count=0, retireValid=0.
- Allocate IDs 1..8 with DEPTH=8 → allocReady=0, count=8, validMask=8'hFF. Complete index 0, then retire → retireId=1, allocReady=1 the next cycle.
- Wrap: with head=6 and tail=2 (4 live entries) → validMask=8'hC3. A done on idx 3 raises errDone the next cycle with no state change.
- Out-of-order: complete idx 2, then idx 1, then idx 0 → retireValid is held until idx 0 is done, then three back-to-back retires return IDs in order.
- Duplicate done on the same live index → second notice pulses errDone, and doneMask is unchanged.
- With INFLIGHT_FLUSH_EN: flush with 5 live entries plus a same-cycle alloc → count=0, validMask=0, and the alloc is dropped.

Source files
------------

// File: rtl/inflight_queue_ctrl_pkg.sv
// Shared types and pointer helpers for the in-flight request window controller.
// Window geometry is fixed here so every block agrees on pointer and index widths.
package inflight_queue_ctrl_pkg;

  localparam int LOG_DEPTH = 3;
  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int ID_WIDTH  = 4;

  // Pointers carry one extra MSB as the wrap bit.
  typedef logic [LOG_DEPTH:0]   ptrT;
  typedef logic [LOG_DEPTH-1:0] idxT;
  typedef logic [ID_WIDTH-1:0]  entryIdT;

  function automatic logic isEmpty(input ptrT headPtr, input ptrT tailPtr);
    return headPtr == tailPtr;
  endfunction

  function automatic logic isFull(input ptrT headPtr, input ptrT tailPtr);
    return (headPtr[LOG_DEPTH-1:0] == tailPtr[LOG_DEPTH-1:0]) &&
           (headPtr[LOG_DEPTH] != tailPtr[LOG_DEPTH]);
  endfunction

endpackage

// File: rtl/inflight_queue_ctrl_if.sv
// Handshake bundle between the prefetcher (master) and the in-flight window controller (slave).
// The flush signal exists only when INFLIGHT_FLUSH_EN is defined.
interface inflight_queue_ctrl_if;
  import inflight_queue_ctrl_pkg::*;

  logic                 allocValid;
  entryIdT              allocId;
  logic                 allocReady;
  idxT                  allocIdx;
  logic                 doneValid;
  idxT                  doneIdx;
  logic                 errDone;
  logic                 retireValid;
  logic                 retireReady;
  entryIdT              retireId;
  idxT                  retireIdx;
  logic [DEPTH-1:0]     validMask;
  logic [DEPTH-1:0]     doneMask;
  ptrT                  count;
`ifdef INFLIGHT_FLUSH_EN
  logic                 flush;
`endif

  modport master (
    output allocValid, allocId, doneValid, doneIdx, retireReady,
`ifdef INFLIGHT_FLUSH_EN
    output flush,
`endif
    input  allocReady, allocIdx, errDone, retireValid, retireId, retireIdx,
           validMask, doneMask, count
  );

  modport slave (
    input  allocValid, allocId, doneValid, doneIdx, retireReady,
`ifdef INFLIGHT_FLUSH_EN
    input  flush,
`endif
    output allocReady, allocIdx, errDone, retireValid, retireId, retireIdx,
           validMask, doneMask, count
  );

endinterface

// File: rtl/inflight_queue_ctrl_range_mask.sv
// Cyclic range mask: bits [headIdx, tailIdx) set, wrapping past the top index.
// Equal indices yield all-ones; the caller gates that with its empty flag.
module inflight_queue_ctrl_range_mask
  import inflight_queue_ctrl_pkg::*;
(
  input  idxT              headIdx,
  input  idxT              tailIdx,
  output logic [DEPTH-1:0] mask
);

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (headIdx < tailIdx)
        mask[i] = (idxT'(i) >= headIdx) && (idxT'(i) < tailIdx);
      else
        mask[i] = (idxT'(i) >= headIdx) || (idxT'(i) < tailIdx);
    end
  end

endmodule

// File: rtl/inflight_queue_ctrl.sv
// In-flight request window: in-order alloc at the tail, out-of-order completion, in-order retire.
// Optional flush port and logic are enabled by defining INFLIGHT_FLUSH_EN.
module inflight_queue_ctrl
  import inflight_queue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  inflight_queue_ctrl_if.slave bus
);

  ptrT              headPtr, tailPtr;
  ptrT              headNext, tailNext;
  logic [DEPTH-1:0] doneQ, doneNext;
  logic             errDoneQ, errNext;
  entryIdT          idMem [DEPTH];

  idxT              headIdx, tailIdx;
  logic             empty, full;
  logic [DEPTH-1:0] rangeMask, validMask;
  logic             flushNow, allocFire, retireFire, doneLegal;

  assign headIdx = headPtr[LOG_DEPTH-1:0];
  assign tailIdx = tailPtr[LOG_DEPTH-1:0];
  assign empty   = isEmpty(headPtr, tailPtr);
  assign full    = isFull(headPtr, tailPtr);

  inflight_queue_ctrl_range_mask uRangeMask (
    .headIdx (headIdx),
    .tailIdx (tailIdx),
    .mask    (rangeMask)
  );

  // Full case falls out of the all-ones result for equal indices.
  assign validMask = empty ? '0 : rangeMask;

`ifdef INFLIGHT_FLUSH_EN
  assign flushNow = bus.flush;
`else
  assign flushNow = 1'b0;
`endif

  assign allocFire  = bus.allocValid && !full && !flushNow;
  assign retireFire = bus.retireValid && bus.retireReady && !flushNow;
  // Qualified against the pre-edge mask, so a notice for the slot being allocated now is illegal.
  assign doneLegal  = bus.doneValid && validMask[bus.doneIdx] && !doneQ[bus.doneIdx];

  always_comb begin
    headNext = headPtr;
    tailNext = tailPtr;
    doneNext = doneQ;
    errNext  = 1'b0;
    if (flushNow) begin
      headNext = tailPtr;
      doneNext = '0;
    end else begin
      if (retireFire) begin
        doneNext[headIdx] = 1'b0;
        headNext          = headPtr + 1'b1;
      end
      if (allocFire) begin
        doneNext[tailIdx] = 1'b0;
        tailNext          = tailPtr + 1'b1;
      end
      if (doneLegal)
        doneNext[bus.doneIdx] = 1'b1;
      errNext = bus.doneValid && !doneLegal;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      doneQ    <= '0;
      errDoneQ <= 1'b0;
    end else begin
      headPtr  <= headNext;
      tailPtr  <= tailNext;
      doneQ    <= doneNext;
      errDoneQ <= errNext;
    end
  end

  // NOTE: ID storage has no reset; an entry is only read after its allocation wrote it.
  always_ff @(posedge clk) begin
    if (allocFire)
      idMem[tailIdx] <= bus.allocId;
  end

  assign bus.allocReady  = !full;
  assign bus.allocIdx    = tailIdx;
  assign bus.errDone     = errDoneQ;
  assign bus.retireValid = !empty && doneQ[headIdx];
  assign bus.retireId    = idMem[headIdx];
  assign bus.retireIdx   = headIdx;
  assign bus.validMask   = validMask;
  assign bus.doneMask    = doneQ & validMask;
  assign bus.count       = tailPtr - headPtr;

endmodule
